// File: rtl/fsm_lights_pkg.sv
// Shared definitions for the traffic light controller: state codes, lamp
// encodings, default phase timings and the state-to-lamp decode.
package fsm_lights_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned LAMP_W  = 3;

    localparam logic [STATE_W-1:0] S_MAIN_GREEN  = 3'd0;
    localparam logic [STATE_W-1:0] S_MAIN_YELLOW = 3'd1;
    localparam logic [STATE_W-1:0] S_ALL_RED1    = 3'd2;
    localparam logic [STATE_W-1:0] S_SIDE_GREEN  = 3'd3;
    localparam logic [STATE_W-1:0] S_SIDE_YELLOW = 3'd4;
    localparam logic [STATE_W-1:0] S_ALL_RED2    = 3'd5;

    localparam logic [LAMP_W-1:0] LAMP_R = 3'b100;
    localparam logic [LAMP_W-1:0] LAMP_Y = 3'b010;
    localparam logic [LAMP_W-1:0] LAMP_G = 3'b001;

    localparam int unsigned DEF_T_MIN_GREEN  = 8;
    localparam int unsigned DEF_T_YELLOW     = 3;
    localparam int unsigned DEF_T_ALL_RED    = 2;
    localparam int unsigned DEF_T_SIDE_GREEN = 6;
    localparam int unsigned DEF_CW           = 8;

    typedef struct packed {
        logic [LAMP_W-1:0] main_lamps;
        logic [LAMP_W-1:0] side_lamps;
    } lamps_t;

    // Unknown codes show red both ways so a corrupted state never opens a road.
    function automatic lamps_t lamp_decode(input logic [STATE_W-1:0] state);
        lamps_t l;
        l.main_lamps = LAMP_R;
        l.side_lamps = LAMP_R;
        case (state)
            S_MAIN_GREEN:  l.main_lamps = LAMP_G;
            S_MAIN_YELLOW: l.main_lamps = LAMP_Y;
            S_SIDE_GREEN:  l.side_lamps = LAMP_G;
            S_SIDE_YELLOW: l.side_lamps = LAMP_Y;
            default:       l.main_lamps = LAMP_R;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase counter: clears on request, otherwise counts up and holds at a limit.
module phase_timer #(
    parameter int unsigned CW = 8
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          i_clear,
    input  logic [CW-1:0] i_sat_limit,
    output logic [CW-1:0] o_count
);

    logic [CW-1:0] r_count;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (r_count != i_sat_limit) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/traffic_light_controller.sv
// Two-road intersection controller: main road rests on green, side road is
// served after a minimum main green once a request has been latched.
module traffic_light_controller
    import fsm_lights_pkg::*;
#(
    parameter int unsigned T_MIN_GREEN  = DEF_T_MIN_GREEN,
    parameter int unsigned T_YELLOW     = DEF_T_YELLOW,
    parameter int unsigned T_ALL_RED    = DEF_T_ALL_RED,
    parameter int unsigned T_SIDE_GREEN = DEF_T_SIDE_GREEN,
    parameter int unsigned CW           = DEF_CW
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Req,
    output logic [LAMP_W-1:0] MainLights,
    output logic [LAMP_W-1:0] SideLights,
    output logic              ReqPending
);

    localparam logic [CW-1:0] MG_LAST = CW'(T_MIN_GREEN - 1);
    localparam logic [CW-1:0] Y_LAST  = CW'(T_YELLOW - 1);
    localparam logic [CW-1:0] AR_LAST = CW'(T_ALL_RED - 1);
    localparam logic [CW-1:0] SG_LAST = CW'(T_SIDE_GREEN - 1);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_next;
    logic [CW-1:0]      w_count;
    logic [CW-1:0]      w_sat_limit;
    logic               w_clear;
    logic               w_serve_side;
    logic               r_req_pending;
    logic [LAMP_W-1:0]  r_main_lights;
    logic [LAMP_W-1:0]  r_side_lights;
    lamps_t             w_lamps_next;

    phase_timer #(
        .CW (CW)
    ) u_phase_timer (
        .Clock       (Clock),
        .Reset       (Reset),
        .i_clear     (w_clear),
        .i_sat_limit (w_sat_limit),
        .o_count     (w_count)
    );

    // Only main green saturates; other phases exit long before all-ones.
    assign w_sat_limit  = (r_state == S_MAIN_GREEN) ? MG_LAST : '1;
    assign w_clear      = (w_state_next != r_state);
    assign w_serve_side = (r_state == S_ALL_RED1) && (w_state_next == S_SIDE_GREEN);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_MAIN_GREEN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_MAIN_GREEN:  if ((w_count == MG_LAST) && (r_req_pending || Req))
                               w_state_next = S_MAIN_YELLOW;
            S_MAIN_YELLOW: if (w_count == Y_LAST)  w_state_next = S_ALL_RED1;
            S_ALL_RED1:    if (w_count == AR_LAST) w_state_next = S_SIDE_GREEN;
            S_SIDE_GREEN:  if (w_count == SG_LAST) w_state_next = S_SIDE_YELLOW;
            S_SIDE_YELLOW: if (w_count == Y_LAST)  w_state_next = S_ALL_RED2;
            S_ALL_RED2:    if (w_count == AR_LAST) w_state_next = S_MAIN_GREEN;
            default:       w_state_next = S_ALL_RED2;
        endcase
    end

    // A new request on the serving edge wins over the clear.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_req_pending <= 1'b0;
        end else if (Req) begin
            r_req_pending <= 1'b1;
        end else if (w_serve_side) begin
            r_req_pending <= 1'b0;
        end
    end

    always_comb begin
        w_lamps_next = lamp_decode(w_state_next);
    end

    // Lamps are registered from the next state so they track r_state exactly.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_main_lights <= LAMP_G;
            r_side_lights <= LAMP_R;
        end else begin
            r_main_lights <= w_lamps_next.main_lamps;
            r_side_lights <= w_lamps_next.side_lamps;
        end
    end

    assign MainLights = r_main_lights;
    assign SideLights = r_side_lights;
    assign ReqPending = r_req_pending;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed bench for traffic_light_controller with default timings; edges are
// numbered from 1 after each reset release.
module tb_traffic_light_controller;

    logic       Clock;
    logic       Reset;
    logic       Req;
    logic [2:0] MainLights;
    logic [2:0] SideLights;
    logic       ReqPending;

    int n_tests;
    int n_fail;

    localparam int P_MG  = 0;
    localparam int P_MY  = 1;
    localparam int P_AR1 = 2;
    localparam int P_SG  = 3;
    localparam int P_SY  = 4;
    localparam int P_AR2 = 5;

    traffic_light_controller dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Req        (Req),
        .MainLights (MainLights),
        .SideLights (SideLights),
        .ReqPending (ReqPending)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Phase after edge e for a cycle whose MAIN_YELLOW starts after edge k.
    function automatic int exp_phase(input int e, input int k);
        int d;
        if (k < 0 || e < k) return P_MG;
        d = e - k;
        if (d < 3)  return P_MY;
        if (d < 5)  return P_AR1;
        if (d < 11) return P_SG;
        if (d < 14) return P_SY;
        if (d < 16) return P_AR2;
        return P_MG;
    endfunction

    function automatic logic [2:0] exp_main(input int p);
        case (p)
            P_MG:    return 3'b001;
            P_MY:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] exp_side(input int p);
        case (p)
            P_SG:    return 3'b001;
            P_SY:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    task automatic do_reset();
        Req   = 1'b0;
        Reset = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        Req   = 1'b0;
        Reset = 1'b1;
        @(posedge Clock);
        #2;
        Reset = 1'b0;
        #1;
        n_tests++;
        if ({MainLights, SideLights, ReqPending} !== {3'b001, 3'b100, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_async main=%b side=%b pend=%b want 001/100/0",
                     MainLights, SideLights, ReqPending);
        end
    endtask

    task automatic test_idle();
        do_reset();
        for (int e = 1; e <= 50; e++) begin
            @(posedge Clock);
            #1;
            n_tests++;
            if ({MainLights, SideLights, ReqPending} !== {3'b001, 3'b100, 1'b0}) begin
                n_fail++;
                $display("FAIL idle e=%0d main=%b side=%b pend=%b want 001/100/0",
                         e, MainLights, SideLights, ReqPending);
            end
        end
    endtask

    task automatic test_req_pulse();
        int p;
        logic ep;
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            Req = (e == 20);
            @(posedge Clock);
            #1;
            Req = 1'b0;
            p  = exp_phase(e, 20);
            ep = (e >= 20 && e < 25);
            n_tests++;
            if ({MainLights, SideLights, ReqPending} !== {exp_main(p), exp_side(p), ep}) begin
                n_fail++;
                $display("FAIL req_pulse e=%0d got %b/%b/%b want %b/%b/%b", e,
                         MainLights, SideLights, ReqPending, exp_main(p), exp_side(p), ep);
            end
            n_tests++;
            if (!$onehot(MainLights) || !$onehot(SideLights) || !(MainLights[2] | SideLights[2])) begin
                n_fail++;
                $display("FAIL lamp_safety e=%0d main=%b side=%b", e, MainLights, SideLights);
            end
        end
    endtask

    task automatic test_early_req();
        int p;
        logic ep;
        do_reset();
        for (int e = 1; e <= 12; e++) begin
            Req = (e == 2);
            @(posedge Clock);
            #1;
            Req = 1'b0;
            p  = exp_phase(e, 8);
            ep = (e >= 2);
            n_tests++;
            if ({MainLights, SideLights, ReqPending} !== {exp_main(p), exp_side(p), ep}) begin
                n_fail++;
                $display("FAIL early_req e=%0d got %b/%b/%b want %b/%b/%b", e,
                         MainLights, SideLights, ReqPending, exp_main(p), exp_side(p), ep);
            end
        end
    endtask

    task automatic test_back_to_back();
        int p;
        logic ep;
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            Req = (e == 10 || e == 17);
            @(posedge Clock);
            #1;
            Req = 1'b0;
            p  = (e >= 34) ? exp_phase(e, 34) : exp_phase(e, 10);
            ep = (e >= 10 && e < 15) || (e >= 17 && e < 39);
            n_tests++;
            if ({MainLights, SideLights, ReqPending} !== {exp_main(p), exp_side(p), ep}) begin
                n_fail++;
                $display("FAIL back_to_back e=%0d got %b/%b/%b want %b/%b/%b", e,
                         MainLights, SideLights, ReqPending, exp_main(p), exp_side(p), ep);
            end
            n_tests++;
            if (!$onehot(MainLights) || !$onehot(SideLights) || !(MainLights[2] | SideLights[2])) begin
                n_fail++;
                $display("FAIL lamp_safety e=%0d main=%b side=%b", e, MainLights, SideLights);
            end
        end
    endtask

    task automatic test_set_wins();
        int p;
        do_reset();
        for (int e = 1; e <= 34; e++) begin
            Req = (e == 1 || e == 13);
            @(posedge Clock);
            #1;
            Req = 1'b0;
            p = (e >= 32) ? exp_phase(e, 32) : exp_phase(e, 8);
            n_tests++;
            if ({MainLights, SideLights, ReqPending} !== {exp_main(p), exp_side(p), 1'b1}) begin
                n_fail++;
                $display("FAIL set_wins e=%0d got %b/%b/%b want %b/%b/1", e,
                         MainLights, SideLights, ReqPending, exp_main(p), exp_side(p));
            end
        end
    endtask

    task automatic test_reset_mid_side();
        int p;
        logic ep;
        do_reset();
        for (int e = 1; e <= 15; e++) begin
            Req = (e == 1 || e == 14);
            @(posedge Clock);
            #1;
            Req = 1'b0;
            p  = exp_phase(e, 8);
            ep = (e < 13) || (e >= 14);
            n_tests++;
            if ({MainLights, SideLights, ReqPending} !== {exp_main(p), exp_side(p), ep}) begin
                n_fail++;
                $display("FAIL mid_side_pre e=%0d got %b/%b/%b want %b/%b/%b", e,
                         MainLights, SideLights, ReqPending, exp_main(p), exp_side(p), ep);
            end
        end
        #2;
        Reset = 1'b0;
        #1;
        n_tests++;
        if ({MainLights, SideLights, ReqPending} !== {3'b001, 3'b100, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_side_reset main=%b side=%b pend=%b want 001/100/0",
                     MainLights, SideLights, ReqPending);
        end
        @(negedge Clock);
        Reset = 1'b1;
        Req   = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            @(posedge Clock);
            #1;
            p = exp_phase(e, 8);
            n_tests++;
            if ({MainLights, SideLights, ReqPending} !== {exp_main(p), exp_side(p), 1'b1}) begin
                n_fail++;
                $display("FAIL restart_count e=%0d got %b/%b/%b want %b/%b/1", e,
                         MainLights, SideLights, ReqPending, exp_main(p), exp_side(p));
            end
        end
        Req = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        Req     = 1'b0;
        Reset   = 1'b0;
        test_reset();
        test_idle();
        test_req_pulse();
        test_early_req();
        test_back_to_back();
        test_set_wins();
        test_reset_mid_side();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_light_controller.md
TRAFFIC_LIGHT_CONTROLLER -- requirements
Module: traffic_light_controller

Interface
REQ-001 Parameter T_MIN_GREEN, default 8, minimum main-road green time in clock cycles (>=1).
REQ-002 Parameter T_YELLOW, default 3, yellow time in cycles for either road (>=1).
REQ-003 Parameter T_ALL_RED, default 2, all-red clearance time in cycles (>=1).
REQ-004 Parameter T_SIDE_GREEN, default 6, side-road green time in cycles (>=1).
REQ-005 Parameter CW, default 8, phase-counter width; every T_* SHALL be <= 2^CW.
REQ-006 Clock  input  1  single clock; all state changes on its rising edge.
REQ-007 Reset  input  1  asynchronous, active-low reset.
REQ-008 Req  input  1  side-road service request from the upstream sequence-detector stage (its Dout), any pulse width, synchronous to Clock.
REQ-009 MainLights  output  3  main-road lamps {R,Y,G}, one-hot.
REQ-010 SideLights  output  3  side-road lamps {R,Y,G}, one-hot.
REQ-011 ReqPending  output  1  high while a latched request awaits service.

Function
REQ-012 States SHALL be MAIN_GREEN, MAIN_YELLOW, ALL_RED1, SIDE_GREEN, SIDE_YELLOW, ALL_RED2.
REQ-013 Lamps SHALL be a Moore decode of state: MAIN_GREEN 001/100, MAIN_YELLOW 010/100, ALL_RED1 100/100, SIDE_GREEN 100/001, SIDE_YELLOW 100/010, ALL_RED2 100/100 (Main/Side).
REQ-014 At no time SHALL both MainLights and SideLights have R=0.
REQ-015 Phase counter SHALL clear to 0 on every state transition and increment by 1 on each rising edge otherwise.
REQ-016 A timed state with duration T SHALL last exactly T cycles: it exits on the edge where count == T-1.
REQ-017 Sequence: MAIN_YELLOW(T_YELLOW) -> ALL_RED1(T_ALL_RED) -> SIDE_GREEN(T_SIDE_GREEN) -> SIDE_YELLOW(T_YELLOW) -> ALL_RED2(T_ALL_RED) -> MAIN_GREEN.
REQ-018 In MAIN_GREEN, the counter SHALL saturate at T_MIN_GREEN-1.
REQ-019 MAIN_GREEN SHALL exit to MAIN_YELLOW on the edge where count == T_MIN_GREEN-1 and (ReqPending==1 or Req==1); otherwise it SHALL remain, indefinitely if no request arrives.
REQ-020 A request SHALL be latched into ReqPending when Req==1 is sampled at a rising edge, in any state.
REQ-021 ReqPending SHALL clear on the ALL_RED1 -> SIDE_GREEN edge; if Req==1 on that same edge, set SHALL win and ReqPending stays 1.
REQ-022 Requests during SIDE_GREEN, SIDE_YELLOW or ALL_RED2 SHALL be held and served after the next full minimum main green; multiple requests SHALL merge into one.
REQ-023 With count saturated and Req sampled at edge k, MAIN_YELLOW SHALL be visible after edge k, SIDE_GREEN after edge k+T_YELLOW+T_ALL_RED, and MAIN_GREEN again after edge k+2*T_YELLOW+2*T_ALL_RED+T_SIDE_GREEN.
REQ-024 Any unreachable state encoding SHALL go to ALL_RED2 on the next edge with the counter cleared.

Reset
REQ-025 Reset==0 SHALL immediately, without waiting for a clock edge, force state MAIN_GREEN, counter 0, ReqPending 0, MainLights 001, SideLights 100.
REQ-026 Assertion of reset mid-sequence, including during SIDE_GREEN, SHALL abandon the sequence and discard the pending request.
REQ-027 After deassertion, MAIN_GREEN SHALL begin its full T_MIN_GREEN count from 0.

Structure
REQ-028 Package fsm_lights_pkg SHALL hold the state enumeration, the lamp encodings (LAMP_R=100, LAMP_Y=010, LAMP_G=001) and default timing constants.
REQ-029 The counter SHALL be a sub-module phase_timer (inputs clear, saturate limit; output count; same Clock/Reset).
REQ-030 State register, next-state logic and output decode SHALL be separate processes.

Verification (defaults)
REQ-031 Reset released, Req=0 for 50 cycles -> MAIN_GREEN throughout, Main=001/Side=100, ReqPending=0.
REQ-032 Req pulse 1 cycle at edge 20 -> MAIN_YELLOW after edge 20, SIDE_GREEN after edge 25 for 6 cycles, MAIN_GREEN after edge 36; ReqPending 1 from edge 20 to edge 25.
REQ-033 Req pulse at edge 2 -> ReqPending=1, MAIN_YELLOW only after edge 8.
REQ-034 Req pulse during SIDE_GREEN -> ReqPending stays 1; a second cycle starts exactly 8 cycles after MAIN_GREEN re-entry.
REQ-035 Reset asserted mid-SIDE_GREEN -> Main=001/Side=100 and ReqPending=0 with no clock edge needed.
REQ-036 Throughout all tests, the REQ-014 assertion SHALL hold every cycle, and each lamp vector SHALL stay one-hot.
